layer_serializer: RTL
=====================

Name: layer_serializer

Overview:
- Sits between two neuron layers.
- The upstream layer presents NN neuron results in parallel, with per-neuron valid bits.
- The downstream layer consumes one input word per cycle with a valid strobe.
- This block captures the parallel result vector, then sequences it out word by word (neuron 0 first) as the next layer's x_in/x_valid stream. It flags overruns and valid skew.

Parameters:
- NN, 10, number of neurons in the upstream layer (≥1).
- dataWidth, 16, width of one neuron output word.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- o_valid  in  NN  per-neuron output-valid pulses from the upstream layer.
- x_in_bus  in  NN*dataWidth  upstream results; neuron k at bits [k*dataWidth +: dataWidth].
- x_out  out  dataWidth  serialized word to the downstream layer.
- x_valid  out  1  x_out is valid this cycle.
- last  out  1  high with the final word (neuron NN-1) of a vector.
- busy  out  1  high while in SEND.
- overrun  out  1  sticky: a vector arrived while busy and could not be accepted.
- skew_err  out  1  sticky: o_valid was neither all-zeros nor all-ones in some cycle.

Behaviour:
- Reset (rst=1 at a clk edge):
  - All outputs go to 0: x_out=0, x_valid=0, last=0, busy=0, overrun=0, skew_err=0.
  - State goes to IDLE, counter to 0, and the buffer is cleared.
  - Reset aborts any SEND in progress; no further words are emitted.
- Accept condition: o_valid[0]==1 at a clock edge. All neurons in a layer fire in the same cycle, so bit 0 is authoritative.
- State machine (2 states):
  - IDLE: busy=0, x_valid=0. On accept, copy x_in_bus into the NN-word buffer, set cnt=0, go to SEND.
  - SEND: each cycle drive x_out=buf[cnt] with x_valid=1 and busy=1, then cnt increments.
    - last=1 when cnt==NN-1.
    - After the cnt==NN-1 cycle, return to IDLE unless a back-to-back accept occurred.
  - All outputs are registered.
- Latency: accept at edge T gives word 0 in cycle T+1 and word k in cycle T+1+k; last is in cycle T+NN. Throughput is one word per clock with no gaps within a vector.
- Back-to-back:
  - An accept in the cycle where cnt==NN-1 is output is legal. The buffer reloads, cnt returns to 0, and the state stays SEND.
  - Word 0 of the new vector appears in the very next cycle, so there is no bubble between vectors.
- Overrun: an accept while in SEND with cnt≠NN-1 is dropped. The buffer is untouched, the current vector completes intact, and overrun is set and stays set until rst.
- Skew: in any cycle where o_valid≠0 and o_valid≠all-ones, skew_err is set (sticky until rst). The accept decision still uses only o_valid[0].
- Counter width: max(1, $clog2(NN)). The counter never exceeds NN-1.
- NN==1: every vector is a single cycle with x_valid=1 and last=1. Back-to-back accepts every cycle are legal and never overrun.
- x_out holds its last driven value when x_valid=0. Consumers must qualify it with x_valid.

Decomposition:
- Shared package (nn_pkg): state encoding constants ST_IDLE/ST_SEND, and a counter-width function clog2_min1(NN).
- No sub-module is needed: the buffer, counter and FSM stay in one module. The buffer is an NN-entry register array, not a RAM, because the full vector is loaded in one cycle.

Test Plan:
1. Basic (NN=10, dataWidth=16):
   - Stimulus: pulse o_valid=10'h3FF for one cycle with word k = 16'h0100*(k+1).
   - Required: x_valid high for exactly 10 cycles starting the next cycle; x_out = 16'h0100, 16'h0200 … 16'h0A00; last high only with 16'h0A00; busy then drops; overrun=0 and skew_err=0.
2. Back-to-back:
   - Stimulus: second all-ones pulse (word k = 16'h1000+k) coincident with last of vector 1.
   - Required: 20 consecutive x_valid cycles; the second run is 16'h1000 … 16'h1009; overrun=0.
3. Overrun:
   - Stimulus: second pulse 3 cycles after the first.
   - Required: the first vector is emitted complete and unchanged; no second vector; overrun=1 and stays 1 until rst.
4. Skew:
   - Stimulus: o_valid=10'h001 for one cycle.
   - Required: skew_err=1; vector still accepted and serialized (10 words).
   - Stimulus: o_valid=10'h002 alone.
   - Required: skew_err=1; no accept; x_valid stays 0.
5. Reset mid-vector:
   - Stimulus: assert rst during word 4.
   - Required: next cycle all outputs are 0 and state is IDLE; no further words; a fresh pulse afterwards serializes normally from word 0.
6. NN=1 build:
   - Stimulus: o_valid=1 on three consecutive cycles with values 16'h0011, 16'h0022, 16'h0033.
   - Required: three consecutive x_valid/last cycles carrying those values in order; overrun=0.

Source files
------------

// File: rtl/nn_pkg.sv
// Shared definitions for the layer serializer: FSM state encoding and counter sizing.
// No logic; no latency or backpressure of its own.
package nn_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    // A counter must be at least one bit wide even when there is a single neuron.
    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/layer_serializer.sv
// Captures a parallel neuron result vector and streams it out one word per clock, neuron 0 first.
// Word 0 appears one cycle after accept; no backpressure: accepts while mid-vector are dropped and flagged.
import nn_pkg::*;

module layer_serializer #(
    parameter int NN        = 10,
    parameter int dataWidth = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NN-1:0]             o_valid,
    input  logic [NN*dataWidth-1:0]   x_in_bus,
    output logic [dataWidth-1:0]      x_out,
    output logic                      x_valid,
    output logic                      last,
    output logic                      busy,
    output logic                      overrun,
    output logic                      skew_err
);

    localparam int             CW       = clog2_min1(NN);
    localparam logic [CW-1:0]  LAST_IDX = CW'(NN - 1);

    state_t                 r_state;
    logic [CW-1:0]          r_cnt;
    logic [dataWidth-1:0]   r_buf [NN];
    logic [dataWidth-1:0]   r_x_out;
    logic                   r_x_valid;
    logic                   r_last;
    logic                   r_busy;
    logic                   r_overrun;
    logic                   r_skew_err;

    logic [dataWidth-1:0]   w_words [NN];
    logic                   w_accept;
    logic                   w_skew;
    logic                   w_at_last;
    logic                   w_load;
    logic [CW-1:0]          w_nxt_cnt;

    for (genvar k = 0; k < NN; k++) begin : g_words
        assign w_words[k] = x_in_bus[k*dataWidth +: dataWidth];
    end

    // Bit 0 alone decides acceptance; the other bits only feed the skew monitor.
    assign w_accept  = o_valid[0];
    assign w_skew    = (o_valid != '0) && (o_valid != '1);
    assign w_at_last = (r_cnt == LAST_IDX);
    assign w_load    = w_accept && ((r_state == ST_IDLE) || w_at_last);
    assign w_nxt_cnt = r_cnt + CW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_buf      <= '{default: '0};
            r_x_out    <= '0;
            r_x_valid  <= 1'b0;
            r_last     <= 1'b0;
            r_busy     <= 1'b0;
            r_overrun  <= 1'b0;
            r_skew_err <= 1'b0;
        end else begin
            if (w_skew)
                r_skew_err <= 1'b1;

            // r_cnt always indexes the word currently on x_out.
            if (w_load) begin
                r_buf     <= w_words;
                r_cnt     <= '0;
                r_state   <= ST_SEND;
                r_x_out   <= w_words[0];
                r_x_valid <= 1'b1;
                r_busy    <= 1'b1;
                r_last    <= (NN == 1);
            end else if (r_state == ST_SEND) begin
                if (w_at_last) begin
                    r_state   <= ST_IDLE;
                    r_x_valid <= 1'b0;
                    r_busy    <= 1'b0;
                    r_last    <= 1'b0;
                end else begin
                    r_cnt   <= w_nxt_cnt;
                    r_x_out <= r_buf[w_nxt_cnt];
                    r_last  <= (w_nxt_cnt == LAST_IDX);
                    if (w_accept)
                        r_overrun <= 1'b1;
                end
            end
        end
    end

    assign x_out    = r_x_out;
    assign x_valid  = r_x_valid;
    assign last     = r_last;
    assign busy     = r_busy;
    assign overrun  = r_overrun;
    assign skew_err = r_skew_err;

endmodule
